// File: rtl/line_fill_ctrl.sv
// line_fill_ctrl: requests one 256-bit line, waits MEM_LAT cycles, then streams it as eight 32-bit beats.
// Optional macro CRIT_WORD_FIRST_EN starts the stream at the requested word and wraps around the line.
module line_fill_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 32
) (
    input  logic              nGCLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic [3:0]        mem_sel,
    input  logic [255:0]      mem_line,
    output logic              fill_valid,
    input  logic              fill_ready,
    output logic [31:0]       fill_data,
    output logic [2:0]        fill_word,
    output logic              fill_last,
    output logic              busy
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    state_t       state_q;
    logic [3:0]   lat_cnt_q;
    logic [2:0]   beat_q;
    logic [255:0] line_buf_q;
    logic [3:0]   mem_sel_q;
    logic         fill_valid_q;
    logic         fill_last_q;
    logic [31:0]  fill_data_q;
    logic [2:0]   fill_word_q;
    logic [2:0]   start_s;
    logic [2:0]   beat_d;
    logic [2:0]   fill_word_d;
    logic         handshake_s;
    logic         unused_addr_s;

    function automatic logic [31:0] word_of(input logic [255:0] line, input logic [2:0] idx);
        return line[{idx, 5'd0} +: 32];
    endfunction

`ifdef CRIT_WORD_FIRST_EN
    logic [2:0] start_q;
    assign start_s       = start_q;
    assign unused_addr_s = ^{req_addr[ADDR_W-1:9], req_addr[1:0]};
`else
    assign start_s       = 3'd0;
    assign unused_addr_s = ^{req_addr[ADDR_W-1:9], req_addr[4:0]};
`endif

    // Position of the next beat; word index wraps modulo 8 by width.
    always_comb begin
        beat_d      = beat_q + 3'd1;
        fill_word_d = start_s + beat_d;
        handshake_s = fill_valid_q & fill_ready;
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign mem_sel    = mem_sel_q;
    assign fill_valid = fill_valid_q;
    assign fill_data  = fill_data_q;
    assign fill_word  = fill_word_q;
    assign fill_last  = fill_last_q;

    // Request / latency / stream FSM with registered beat outputs.
    always_ff @(posedge nGCLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            lat_cnt_q    <= 4'd0;
            beat_q       <= 3'd0;
            line_buf_q   <= 256'd0;
            mem_sel_q    <= 4'd0;
            fill_valid_q <= 1'b0;
            fill_last_q  <= 1'b0;
            fill_data_q  <= 32'd0;
            fill_word_q  <= 3'd0;
`ifdef CRIT_WORD_FIRST_EN
            start_q      <= 3'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        mem_sel_q <= req_addr[8:5];
                        lat_cnt_q <= LAT_INIT;
                        state_q   <= WAIT;
`ifdef CRIT_WORD_FIRST_EN
                        start_q   <= req_addr[4:2];
`endif
                    end
                end
                WAIT: begin
                    if (lat_cnt_q == 4'd0) begin
                        line_buf_q   <= mem_line;
                        beat_q       <= 3'd0;
                        fill_valid_q <= 1'b1;
                        fill_word_q  <= start_s;
                        fill_data_q  <= word_of(mem_line, start_s);
                        fill_last_q  <= 1'b0;
                        state_q      <= STREAM;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end
                STREAM: begin
                    if (handshake_s) begin
                        if (beat_q == 3'd7) begin
                            fill_valid_q <= 1'b0;
                            fill_last_q  <= 1'b0;
                            state_q      <= IDLE;
                        end else begin
                            beat_q      <= beat_d;
                            fill_word_q <= fill_word_d;
                            fill_data_q <= word_of(line_buf_q, fill_word_d);
                            fill_last_q <= (beat_d == 3'd7);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
